// File: rtl/serial_add_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : serial_add_ctrl (with helper cell full_adder)                |
// | Description : Bit-serial adder controller. Reuses one single-bit           |
// |               full_adder over WIDTH cycles, LSB first, to produce          |
// |               {cout,sum} = a + b + cin. Valid/ready handshakes on both     |
// |               the operand and the result side; back-to-back capable.       |
// | Ports       : clk, rst (async, active-high)                                |
// |               in_valid/in_ready, a, b, cin   - operand side                |
// |               out_valid/out_ready, sum, cout - result side                 |
// |               busy                           - high while bits are shifted |
// |               sub (only with SERIAL_ADD_SUB_EN) - subtract a - b - cin     |
// | Options     : `define SERIAL_ADD_SUB_EN to add the sub port               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum_sh;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             w_accept;
   logic             w_last;
   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

`ifdef SERIAL_ADD_SUB_EN
   // a - b - cin == a + ~b + ~cin; cout=1 then means "no borrow".
   assign w_b_load = sub ? ~b   : b;
   assign w_c_load = sub ? ~cin : cin;
`else
   assign w_b_load = b;
   assign w_c_load = cin;
`endif

   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_cnt == c_last_bit);

   full_adder u_fa (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            // Retiring the result frees the datapath this very edge, so a
            // waiting operand pair can be taken without an IDLE bubble.
            in_ready  = out_ready;
            if (out_ready) w_state_nxt = in_valid ? S_RUN : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand/result shifters, carry, bit counter, carry-out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
      end else if (w_accept) begin
         // r_sum_sh is left alone: the last result stays visible in IDLE.
         r_a_sh  <= a;
         r_b_sh  <= w_b_load;
         r_carry <= w_c_load;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
         r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
         r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
         r_carry  <= w_co;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) r_cout <= w_co;
      end
   end

   assign sum  = r_sum_sh;
   assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_add_ctrl                                           |
// | Description : Directed self-checking bench for serial_add_ctrl (WIDTH=8). |
// |               Covers reset values, exact latency, carry-in/out, result    |
// |               backpressure, back-to-back accept, reset mid-RUN and, when  |
// |               SERIAL_ADD_SUB_EN is defined, subtract mode.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands from IDLE and let the next edge accept them.
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic isub);
      a = ia; b = ib; cin = ic; sub = isub; in_valid = 1'b1;
      #1;
      check("issue_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      // Scramble inputs: only the accepting edge may sample them.
      a = ~ia; b = ~ib; cin = ~ic; sub = ~isub;
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_in_ready", 32'(in_ready), 32'd0);
   endtask

   // Called just after the accepting edge; result must appear on edge +WIDTH.
   task automatic wait_result(input string tag, input logic [7:0] es, input logic ec);
      for (int i = 1; i < WIDTH; i++) begin
         tick();
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      end
      tick();
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
   endtask

   // Retire the result with no new operands; sum must persist in IDLE.
   task automatic retire(input string tag, input logic [7:0] es);
      out_ready = 1'b1;
      #1;
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd1);
      tick();
      out_ready = 1'b0;
      check({tag, "_valid_cleared"}, 32'(out_valid), 32'd0);
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_sum_kept"}, 32'(sum), 32'(es));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);

      // 5A + 3C + 0 = 096
      issue(8'h5A, 8'h3C, 1'b0, 1'b0);
      wait_result("add1", 8'h96, 1'b0);
      check("add1_in_ready_blocked", 32'(in_ready), 32'd0);
      retire("add1", 8'h96);

      // FF + 01 + 1 = 101
      issue(8'hFF, 8'h01, 1'b1, 1'b0);
      wait_result("add2", 8'h01, 1'b1);
      retire("add2", 8'h01);

      // 00 + 00 + 0 = 000
      issue(8'h00, 8'h00, 1'b0, 1'b0);
      wait_result("add3", 8'h00, 1'b0);
      retire("add3", 8'h00);

      // F0 + 20 + 1 = 111, then hold the result under backpressure
      issue(8'hF0, 8'h20, 1'b1, 1'b0);
      wait_result("bp", 8'h11, 1'b1);
      a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_sum", 32'(sum), 32'h11);
         check("bp_hold_cout", 32'(cout), 32'd1);
         check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      // Retire and accept 01 + 02 on the same edge
      out_ready = 1'b1;
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      a = 8'hEE; b = 8'hEE; cin = 1'b1;
      check("b2b_valid_dropped", 32'(out_valid), 32'd0);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_result("b2b", 8'h03, 1'b0);
      retire("b2b", 8'h03);

      // Reset after 3 bits of an operation
      issue(8'h55, 8'h55, 1'b0, 1'b0);
      repeat (3) tick();
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("postrst_out_valid", 32'(out_valid), 32'd0);
      issue(8'h10, 8'h20, 1'b0, 1'b0);
      wait_result("postrst", 8'h30, 1'b0);
      retire("postrst", 8'h30);

`ifdef SERIAL_ADD_SUB_EN
      // 10 - 01 - 0 = 0F, no borrow
      issue(8'h10, 8'h01, 1'b0, 1'b1);
      wait_result("sub1", 8'h0F, 1'b1);
      retire("sub1", 8'h0F);
      // 00 - 01 - 0 = FF, borrow
      issue(8'h00, 8'h01, 1'b0, 1'b1);
      wait_result("sub2", 8'hFF, 1'b0);
      retire("sub2", 8'hFF);
      // sub=0 behaves as add
      issue(8'h10, 8'h01, 1'b1, 1'b0);
      wait_result("sub0", 8'h12, 1'b0);
      retire("sub0", 8'h12);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
